// File: rtl/prio_pkg_v.sv
// Shared definitions for the priority scanner: state encoding and clog2.
package prio_pkg_v;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    // Ceiling log2, minimum 1 so a 2-wide vector still gets a 1-bit index.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) r = unsigned'(i + 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/priority_enc_n_v.sv
// Combinational find-first over a request vector.
// Build option PRIORITY_SCAN_MSB_FIRST_EN: highest set index wins instead of lowest.
module priority_enc_n_v
    import prio_pkg_v::*;
#(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned IDX_W = clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan so that the winning bit is the last one assigned.
    always_comb begin
        idx = '0;
        any = |req;
`ifdef PRIORITY_SCAN_MSB_FIRST_EN
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (req[i]) idx = IDX_W'(i);
        end
`else
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
`endif
    end

endmodule

// File: rtl/priority_scan_n_v.sv
// Priority scanner: captures a request vector and hands out pending indices one
// per handshake, in priority order, until the vector is exhausted or flushed.
// Build option PRIORITY_SCAN_MSB_FIRST_EN: highest set index is reported first.
module priority_scan_n_v
    import prio_pkg_v::*;
#(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned IDX_W = clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_code,
    input  logic             i_ready,
    input  logic             i_flush,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_code,
    output logic             o_last,
    output logic             o_busy,
    output logic             o_empty
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             empty_q, empty_d;

    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic             single;
    logic             in_scan;

    priority_enc_n_v #(
        .WIDTH (WIDTH)
    ) u_enc (
        .req (pending_q),
        .idx (enc_idx),
        .any (enc_any)
    );

    // Exactly one bit set: nonzero and clearing the lowest bit leaves nothing.
    assign single  = enc_any && ((pending_q & (pending_q - ONE)) == '0);
    assign in_scan = (state_q == SCAN);

    // Outputs depend only on registered state, never on inputs.
    always_comb begin
        o_valid = in_scan;
        o_code  = in_scan ? enc_idx : '0;
        o_last  = in_scan && single;
        o_busy  = in_scan;
        o_empty = empty_q;
    end

    // Next-state: load in IDLE, retire one index per handshake in SCAN.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        empty_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Flush outranks load while idle.
                if (!i_flush && i_load) begin
                    if (i_code != '0) begin
                        pending_d = i_code;
                        state_d   = SCAN;
                    end else begin
                        empty_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (i_flush) begin
                    pending_d = '0;
                    state_d   = IDLE;
                end else if (i_ready) begin
                    pending_d = pending_q & ~(ONE << enc_idx);
                    if (single) state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            empty_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            empty_q   <= empty_d;
        end
    end

endmodule
